// File: rtl/arbitro_nota_arduino.sv
// Purpose: arbitrates and sequences the 3-bit note channel for the buzzer (musica, botao, alerta).
// Latency: a request sampled in IDLE gives its ack and first note one cycle later.
// Backpressure: losers get no ack and must hold req/data until their own ack pulse.
//
// Ports:
//   clock, reset                  - single clock, synchronous active-high reset
//   req_musica/nota_musica        - playback note request (note 0 = rest)
//   req_botao/nota_botao          - button feedback note request
//   req_alerta/codigo_alerta      - jingle request (01 acerto, 10 erro, 11 fim, 00 none)
//   ack_musica/botao/alerta       - one-cycle grant pulses
//   arduino_out                   - registered note code, 000 = silence
//   ocupado, fonte, db_estado     - busy flag, current owner, state for debug
// Optional feature macro: ALERT_PREEMPT_EN lets a jingle cut short a musica/botao note.
module arbitro_nota_arduino #(
  parameter int W_TIMER = 25,
  parameter int T_NOTA  = 25000000,
  parameter int T_PAUSA = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_musica,
  input  logic [2:0] nota_musica,
  input  logic       req_botao,
  input  logic [2:0] nota_botao,
  input  logic       req_alerta,
  input  logic [1:0] codigo_alerta,
  output logic       ack_musica,
  output logic       ack_botao,
  output logic       ack_alerta,
  output logic [2:0] arduino_out,
  output logic       ocupado,
  output logic [1:0] fonte,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    NOTA  = 2'b01,
    PAUSA = 2'b10
  } estado_t;

  localparam logic [1:0] F_NENHUM = 2'b00;
  localparam logic [1:0] F_MUSICA = 2'b01;
  localparam logic [1:0] F_BOTAO  = 2'b10;
  localparam logic [1:0] F_ALERTA = 2'b11;

  // Timer counts down from duration-1, so a state lasts exactly its duration.
  localparam logic [W_TIMER-1:0] CARGA_NOTA  = W_TIMER'(T_NOTA - 1);
  localparam logic [W_TIMER-1:0] CARGA_PAUSA = W_TIMER'(T_PAUSA - 1);

  estado_t              estado_q, estado_d;
  logic [W_TIMER-1:0]   timer_q, timer_d;
  logic [1:0]           indice_q, indice_d;
  logic [2:0]           nota_q, nota_d;
  logic [1:0]           codigo_q, codigo_d;
  logic [1:0]           fonte_q, fonte_d;
  logic [2:0]           arduino_q, arduino_d;
  logic                 ack_musica_q, ack_musica_d;
  logic                 ack_botao_q, ack_botao_d;
  logic                 ack_alerta_q, ack_alerta_d;
  logic [1:0]           prox_indice;

  function automatic logic [2:0] nota_jingle(input logic [1:0] codigo, input logic [1:0] indice);
    logic [2:0] n;
    n = 3'd0;
    case (codigo)
      2'b01: n = (indice == 2'd0) ? 3'd1 : (indice == 2'd1) ? 3'd3 : 3'd5;
      2'b10: n = (indice == 2'd0) ? 3'd7 : (indice == 2'd1) ? 3'd4 : 3'd1;
      2'b11: n = (indice == 2'd0) ? 3'd1 : (indice == 2'd1) ? 3'd5 : 3'd7;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  always_comb begin
    estado_d     = estado_q;
    timer_d      = timer_q;
    indice_d     = indice_q;
    nota_d       = nota_q;
    codigo_d     = codigo_q;
    fonte_d      = fonte_q;
    ack_musica_d = 1'b0;
    ack_botao_d  = 1'b0;
    ack_alerta_d = 1'b0;
    prox_indice  = indice_q + 2'd1;

    case (estado_q)
      IDLE: begin
        if (req_alerta) begin
          ack_alerta_d = 1'b1;
          // Code 00 is acknowledged but plays nothing; the block stays idle.
          if (codigo_alerta != 2'b00) begin
            codigo_d = codigo_alerta;
            indice_d = 2'd0;
            nota_d   = nota_jingle(codigo_alerta, 2'd0);
            fonte_d  = F_ALERTA;
            estado_d = NOTA;
            timer_d  = CARGA_NOTA;
          end
        end else if (req_botao) begin
          ack_botao_d = 1'b1;
          nota_d      = nota_botao;
          fonte_d     = F_BOTAO;
          estado_d    = NOTA;
          timer_d     = CARGA_NOTA;
        end else if (req_musica) begin
          ack_musica_d = 1'b1;
          nota_d       = nota_musica;
          fonte_d      = F_MUSICA;
          estado_d     = NOTA;
          timer_d      = CARGA_NOTA;
        end
      end
      NOTA: begin
        if (timer_q == '0) begin
          estado_d = PAUSA;
          timer_d  = CARGA_PAUSA;
        end else begin
          timer_d = timer_q - W_TIMER'(1);
        end
      end
      PAUSA: begin
        if (timer_q == '0) begin
          // A jingle chains straight into its next note with no idle cycle.
          if (fonte_q == F_ALERTA && indice_q < 2'd2) begin
            indice_d = prox_indice;
            nota_d   = nota_jingle(codigo_q, prox_indice);
            estado_d = NOTA;
            timer_d  = CARGA_NOTA;
          end else begin
            estado_d = IDLE;
            fonte_d  = F_NENHUM;
          end
        end else begin
          timer_d = timer_q - W_TIMER'(1);
        end
      end
      default: begin
        estado_d = IDLE;
        fonte_d  = F_NENHUM;
      end
    endcase

`ifdef ALERT_PREEMPT_EN
    // A real jingle truncates a musica/botao note or pause; jingles are never cut.
    if (estado_q != IDLE && (fonte_q == F_MUSICA || fonte_q == F_BOTAO) &&
        req_alerta && codigo_alerta != 2'b00) begin
      ack_alerta_d = 1'b1;
      codigo_d     = codigo_alerta;
      indice_d     = 2'd0;
      nota_d       = nota_jingle(codigo_alerta, 2'd0);
      fonte_d      = F_ALERTA;
      estado_d     = NOTA;
      timer_d      = CARGA_NOTA;
    end
`endif

    arduino_d = (estado_d == NOTA) ? nota_d : 3'b000;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= IDLE;
      timer_q      <= '0;
      indice_q     <= 2'd0;
      nota_q       <= 3'd0;
      codigo_q     <= 2'b00;
      fonte_q      <= F_NENHUM;
      arduino_q    <= 3'b000;
      ack_musica_q <= 1'b0;
      ack_botao_q  <= 1'b0;
      ack_alerta_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      timer_q      <= timer_d;
      indice_q     <= indice_d;
      nota_q       <= nota_d;
      codigo_q     <= codigo_d;
      fonte_q      <= fonte_d;
      arduino_q    <= arduino_d;
      ack_musica_q <= ack_musica_d;
      ack_botao_q  <= ack_botao_d;
      ack_alerta_q <= ack_alerta_d;
    end
  end

  assign ack_musica  = ack_musica_q;
  assign ack_botao   = ack_botao_q;
  assign ack_alerta  = ack_alerta_q;
  assign arduino_out = arduino_q;
  assign fonte       = fonte_q;
  assign db_estado   = estado_q;
  assign ocupado     = (estado_q != IDLE);

endmodule

// File: tb/tb_arbitro_nota_arduino.sv
// Purpose: self-checking bench for arbitro_nota_arduino with T_NOTA=4, T_PAUSA=2.
// Latency: expected per-cycle outputs are queued with the stimulus and popped each cycle.
// Backpressure: bench requesters hold req until they see their own ack, then drop it.
module tb_arbitro_nota_arduino;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_musica = 1'b0;
  logic [2:0] nota_musica = 3'd0;
  logic       req_botao = 1'b0;
  logic [2:0] nota_botao = 3'd0;
  logic       req_alerta = 1'b0;
  logic [1:0] codigo_alerta = 2'b00;
  logic       ack_musica, ack_botao, ack_alerta;
  logic [2:0] arduino_out;
  logic       ocupado;
  logic [1:0] fonte;
  logic [1:0] db_estado;

  arbitro_nota_arduino #(
    .W_TIMER(8),
    .T_NOTA (4),
    .T_PAUSA(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_musica   (req_musica),
    .nota_musica  (nota_musica),
    .req_botao    (req_botao),
    .nota_botao   (nota_botao),
    .req_alerta   (req_alerta),
    .codigo_alerta(codigo_alerta),
    .ack_musica   (ack_musica),
    .ack_botao    (ack_botao),
    .ack_alerta   (ack_alerta),
    .arduino_out  (arduino_out),
    .ocupado      (ocupado),
    .fonte        (fonte),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  localparam logic [1:0] E_IDLE = 2'b00, E_NOTA = 2'b01, E_PAUSA = 2'b10;
  localparam logic [1:0] F_NEN = 2'b00, F_MUS = 2'b01, F_BOT = 2'b10, F_ALE = 2'b11;
  localparam logic [2:0] A_NEN = 3'b000, A_MUS = 3'b001, A_BOT = 3'b010, A_ALE = 3'b100;

  typedef struct {
    logic [2:0] out;
    logic [1:0] est;
    logic [1:0] fonte;
    logic [2:0] acks;   // {alerta, botao, musica}
  } esp_t;

  esp_t  exp_q[$];
  int    n_verif = 0;
  int    n_falhas = 0;
  int    cyc = 0;
  string cenario = "";

  task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_verif++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Queue n cycles of identical expected outputs; the ack pattern applies only to the first.
  task automatic seg(input int n, input logic [2:0] out, input logic [1:0] est,
                     input logic [1:0] fnt, input logic [2:0] acks);
    esp_t e;
    for (int i = 0; i < n; i++) begin
      e.out   = out;
      e.est   = est;
      e.fonte = fnt;
      e.acks  = (i == 0) ? acks : A_NEN;
      exp_q.push_back(e);
    end
  endtask

  task automatic amostra();
    esp_t  e;
    string t;
    @(negedge clock);
    t = $sformatf("%s c%0d", cenario, cyc);
    if (exp_q.size() == 0) begin
      verifica({t, " sb_vazio"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      verifica({t, " out"},     {5'd0, arduino_out}, {5'd0, e.out});
      verifica({t, " estado"},  {6'd0, db_estado}, {6'd0, e.est});
      verifica({t, " ocupado"}, {7'd0, ocupado}, {7'd0, (e.est != E_IDLE)});
      verifica({t, " fonte"},   {6'd0, fonte}, {6'd0, e.fonte});
      verifica({t, " acks"},    {5'd0, ack_alerta, ack_botao, ack_musica}, {5'd0, e.acks});
    end
  endtask

  task automatic avanca();
    @(posedge clock);
    #1;
    cyc++;
    if (ack_musica) req_musica = 1'b0;
    if (ack_botao)  req_botao  = 1'b0;
    if (ack_alerta) req_alerta = 1'b0;
  endtask

  task automatic roda(input int n);
    for (int k = 0; k < n; k++) begin
      amostra();
      avanca();
    end
  endtask

  task automatic inicia(input string nome);
    cenario    = nome;
    req_musica = 1'b0;
    req_botao  = 1'b0;
    req_alerta = 1'b0;
    reset      = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    exp_q.delete();
  endtask

  task automatic fecha();
    verifica({cenario, " sb_restante"}, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    // Single musica note 3
    inicia("musica3");
    req_musica = 1'b1; nota_musica = 3'd3;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd3, E_NOTA, F_MUS, A_MUS);
    seg(2, 3'd0, E_PAUSA, F_MUS, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(8);
    fecha();

    // botao beats musica; musica waits and is served after the first IDLE cycle
    inicia("botao_musica");
    req_botao = 1'b1; nota_botao = 3'd5;
    req_musica = 1'b1; nota_musica = 3'd2;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd5, E_NOTA, F_BOT, A_BOT);
    seg(2, 3'd0, E_PAUSA, F_BOT, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd2, E_NOTA, F_MUS, A_MUS);
    seg(2, 3'd0, E_PAUSA, F_MUS, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(15);
    fecha();

    // erro jingle; code changed mid-jingle must be ignored
    inicia("alerta_erro");
    req_alerta = 1'b1; codigo_alerta = 2'b10;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd7, E_NOTA, F_ALE, A_ALE);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd4, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd1, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(2);
    codigo_alerta = 2'b01;
    roda(18);
    fecha();

    // Alert code 00: ack only, stays idle and silent
    inicia("alerta_00");
    req_alerta = 1'b1; codigo_alerta = 2'b00;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_ALE);
    seg(2, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(4);
    fecha();

    // musica note 6, acerto alert raised at cycle 2
    inicia("preempt");
    req_musica = 1'b1; nota_musica = 3'd6;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
`ifdef ALERT_PREEMPT_EN
    seg(2, 3'd6, E_NOTA, F_MUS, A_MUS);
    seg(4, 3'd1, E_NOTA, F_ALE, A_ALE);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd3, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd5, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(2);
    req_alerta = 1'b1; codigo_alerta = 2'b01;
    roda(20);
`else
    seg(4, 3'd6, E_NOTA, F_MUS, A_MUS);
    seg(2, 3'd0, E_PAUSA, F_MUS, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd1, E_NOTA, F_ALE, A_ALE);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd3, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(4, 3'd5, E_NOTA, F_ALE, A_NEN);
    seg(2, 3'd0, E_PAUSA, F_ALE, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(2);
    req_alerta = 1'b1; codigo_alerta = 2'b01;
    roda(25);
`endif
    fecha();

    // Reset in cycle 3 of note 4; botao held through reset is served afterwards
    inicia("reset_meio");
    req_musica = 1'b1; nota_musica = 3'd4;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(3, 3'd4, E_NOTA, F_MUS, A_MUS);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd5, E_NOTA, F_BOT, A_BOT);
    seg(2, 3'd0, E_PAUSA, F_BOT, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(2);
    req_botao = 1'b1; nota_botao = 3'd5;
    roda(1);
    reset = 1'b1;
    roda(1);
    reset = 1'b0;
    roda(8);
    fecha();

    // Rest note: silent but busy, full NOTA/PAUSA sequence
    inicia("pausa_nota0");
    req_musica = 1'b1; nota_musica = 3'd0;
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    seg(4, 3'd0, E_NOTA, F_MUS, A_MUS);
    seg(2, 3'd0, E_PAUSA, F_MUS, A_NEN);
    seg(1, 3'd0, E_IDLE, F_NEN, A_NEN);
    roda(8);
    fecha();

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule

// File: doc/arbitro_nota_arduino.md
# arbitro_nota_arduino

Arbiter and sequencer for the 3-bit note channel driven to the Arduino buzzer. It shares the channel between three requesters: melody playback from memory, player button feedback and the success/error jingle. It times every note and inter-note pause, and plays the multi-note alert jingles on its own. It sits between the game control unit and the data flow, and its `arduino_out` is the single driver of the top-level `arduino_out` pins.

## Interface
Parameters:
- `W_TIMER`, 25: width of the duration timer.
- `T_NOTA`, 25000000: note duration in clock cycles (≥1, < 2^W_TIMER).
- `T_PAUSA`, 5000000: silence after each note in cycles (≥1, < 2^W_TIMER).

Ports:
- `clock`  in  1: the block's one clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_musica`  in  1: playback requests one note.
- `nota_musica`  in  3: playback note; 0 means rest, 1..7 means note.
- `req_botao`  in  1: button feedback requests one note.
- `nota_botao`  in  3: feedback note.
- `req_alerta`  in  1: request a jingle.
- `codigo_alerta`  in  2: jingle select; 01 acerto, 10 erro, 11 fim, 00 none.
- `ack_musica`, `ack_botao`, `ack_alerta`  out  1 each: one-cycle grant pulses.
- `arduino_out`  out  3: registered note code; 000 means silence.
- `ocupado`  out  1: high when the state is not IDLE.
- `fonte`  out  2: current owner; 00 none, 01 musica, 10 botao, 11 alerta.
- `db_estado`  out  2: 00 IDLE, 01 NOTA, 10 PAUSA.

## Operation
- States are IDLE, NOTA and PAUSA.
- The block also holds a jingle index of 0..2, a note register and a timer.
- In IDLE, requests are sampled with fixed priority: alerta, then botao, then musica.
- Granting a request does the following on the next edge:
  - pulses the winner's `ack_*` for exactly 1 cycle;
  - latches its note (alerta latches jingle note 0);
  - loads `fonte`;
  - moves to NOTA.
- Losers are not acknowledged. Each must hold its `req` and data stable until its own ack.
- NOTA: `arduino_out` equals the latched note for exactly T_NOTA cycles, then the state moves to PAUSA.
- PAUSA: `arduino_out` is 000 for exactly T_PAUSA cycles. What follows depends on the owner:
  - owner alerta with index < 2: increment the index, latch the next jingle note, return to NOTA;
  - otherwise: go to IDLE and set `fonte` to 00.
- Jingle notes, in order:
  - acerto: 1, 3, 5
  - erro: 7, 4, 1
  - fim: 1, 5, 7
- `codigo_alerta` is latched at grant time. Later changes have no effect.
- Code 00 is acknowledged in the cycle after sampling. The block stays in IDLE and `arduino_out` stays 000.
- A note value of 0 (rest) follows the normal NOTA/PAUSA sequence with `arduino_out` at 000. `ocupado` stays high throughout.
- A `req` still high in the cycle after its ack counts as a new request. It is arbitrated at the next IDLE cycle.
- The timer counts down from the loaded duration minus 1. It reloads on every state entry, so there is no wrap-around.

## Timing
- Reset: on the edge where `reset`=1, the block behaves as follows.
  - All outputs go to 0.
  - The state goes to IDLE; the timer and index clear.
  - Requests are ignored in that cycle.
  - Reset applied mid-note takes effect on that edge, with no completion of the current note or pause.
- Latency: request seen in IDLE at cycle n gives ack and the first `arduino_out` value at cycle n+1.
- Single note:
  - NOTA spans cycles n+1 to n+T_NOTA;
  - PAUSA spans n+T_NOTA+1 to n+T_NOTA+T_PAUSA;
  - IDLE at n+T_NOTA+T_PAUSA+1, which is also the earliest next sample;
  - period T_NOTA+T_PAUSA+1.
- Jingle: busy for 3·(T_NOTA+T_PAUSA) cycles. There is no IDLE cycle between jingle notes.
- Simultaneous requests in one IDLE cycle are resolved by priority alone.

## Configuration
- `ALERT_PREEMPT_EN` defined: `req_alerta` with a nonzero code, sampled while in NOTA or PAUSA with `fonte` equal to 01 or 10, preempts the current note.
  - On the next edge: pulse `ack_alerta`, set `fonte`=11, index=0, enter NOTA with jingle note 0, reload the timer.
  - The preempted note is simply truncated. Its requester has already been acknowledged and gets nothing further.
  - An alert in progress is never preempted.
- `ALERT_PREEMPT_EN` not defined: alerts are sampled only in IDLE, with the same priority as the other requests.

## Test plan
All scenarios use T_NOTA=4, T_PAUSA=2, with `req` asserted at cycle 0 in IDLE.
- `req_musica` with note 3:
  - `ack_musica` at cycle 1;
  - `arduino_out`=3 in cycles 1-4, 0 in cycles 5-6;
  - `ocupado` in cycles 1-6; IDLE at cycle 7.
- `req_botao` with note 5 and `req_musica` with note 2, both held:
  - botao is acknowledged at cycle 1 and plays 5 in cycles 1-4;
  - `ack_musica` at cycle 8, with `arduino_out`=2 in cycles 8-11.
- `req_alerta` with code 10, and an alert with code 00:
  - code 10 plays 7 in cycles 1-4, 0 in 5-6, 4 in 7-10, 0 in 11-12, 1 in 13-16, 0 in 17-18;
  - code 10 returns to IDLE at cycle 19 with `fonte`=00;
  - code 00 gives an ack pulse, `ocupado` stays 0 and `arduino_out` stays 0.
- Musica note 6 granted; `req_alerta` with code 01 sampled at cycle 2:
  - with the macro: `ack_alerta` at cycle 3 and `arduino_out`=1 in cycles 3-6;
  - without the macro: note 6 plays in cycles 1-4, then `ack_alerta` at cycle 8.
- `reset` high at cycle 3 of a note 4:
  - cycle 4 shows every output at 0 and the state IDLE;
  - a `req_botao` held through the reset is acknowledged at the cycle after the first IDLE cycle with `reset`=0.
- Musica note 0 (rest):
  - `ack_musica` at cycle 1;
  - `arduino_out`=0 throughout, with `ocupado` high in cycles 1-6 and `db_estado` going 01 then 10.
